m_lsu: RTL and testbench
========================

// Module: m_lsu
// PURPOSE
//  M-stage load/store unit: replaces the purely combinational load extractor with a handshaked,
//  multi-cycle data-memory port. Aligns store data and generates byte enables; extracts and
//  sign/zero-extends load data; detects misaligned and illegal accesses and bus timeouts.
//  Stalls the pipeline until the access completes.
//  Sits between the M-stage pipeline register and the data bus (DM or bridge).
// PARAMETERS
//  DATA_W   32  bus/data width: 32 or 64; NB = DATA_W/8 byte lanes
//  ADDR_W   32  byte-address width
//  TIMEOUT  15  max REQ cycles without bus_ack before abort (>=1)
// PORTS
//  clk        in   1       single clock, rising edge
//  reset      in   1       synchronous, active-high
//  req_valid  in   1       M-stage instruction is a memory op
//  req_we     in   1       1 = store, 0 = load
//  req_op     in   3       0 NONE,1 W,2 H,3 B,4 HU,5 BU,6 D,7 WU (D/WU only when DATA_W=64)
//  req_addr   in   ADDR_W  byte address
//  req_wdata  in   DATA_W  store data, right-justified
//  stall      out  1       freeze pipeline (combinational)
//  rsp_valid  out  1       one-cycle completion pulse
//  rsp_rdata  out  DATA_W  extended load result (0 for stores/errors)
//  rsp_err    out  1       bus error, timeout or illegal op (valid with rsp_valid)
//  exc_adel   out  1       misaligned load (valid with rsp_valid)
//  exc_ades   out  1       misaligned store (valid with rsp_valid)
//  bus_req    out  1       request, held until bus_ack
//  bus_we     out  1
//  bus_addr   out  ADDR_W  address with low log2(NB) bits cleared
//  bus_be     out  NB      byte enables (stores); all ones for loads
//  bus_wdata  out  DATA_W  lane-replicated store data
//  bus_ack    in   1       completes the current request
//  bus_rdata  in   DATA_W  valid with bus_ack
//  bus_err    in   1       valid with bus_ack
// BEHAVIOUR
//  - Reset: state IDLE; every registered output 0; stall forced 0 while reset=1. Reset wins
//    over every other event, including mid-access; bus_req drops the cycle after reset is sampled.
//  - FSM IDLE -> REQ -> DONE -> IDLE; IDLE -> FAULT -> IDLE.
//  - IDLE: when req_valid && req_op!=0: stall=1; capture op/we/lane=addr[log2(NB)-1:0]. Aligned
//    and legal -> REQ. Otherwise -> FAULT, with no bus activity.
//  - Alignment: W/WU need addr[1:0]==0; H/HU need addr[0]==0; D needs addr[2:0]==0; B/BU are
//    always aligned.
//  - Illegal: we=1 with HU/BU/WU; D/WU when DATA_W=32.
//  - REQ: bus_req=1, stall=1, wait counter increments. On bus_ack: latch the extracted rdata and
//    rsp_err=bus_err, then -> DONE. If the counter reaches TIMEOUT with no ack: rsp_err=1,
//    rdata=0 -> DONE. A late ack after abort is ignored.
//  - DONE/FAULT: rsp_valid=1 for exactly one cycle; stall=0 so the pipeline advances;
//    req_valid is ignored in this cycle. In FAULT, exc_adel/exc_ades reflect the misalignment
//    (priority over illegal). rsp_err=1 only when the access is illegal but aligned.
//  - Latency: aligned access acked on first REQ cycle = stall for 2 cycles, rsp in 3rd cycle.
//  - Store alignment:
//      B:  byte replicated NB times, be = 1<<lane
//      H:  half replicated, be = 2'b11<<lane
//      W:  word replicated, be = 4'hF<<lane
//      D:  be = all ones
//  - Load extraction: take 8/16/32 bits at byte offset lane of bus_rdata.
//    B/H/W sign-extend to DATA_W; BU/HU/WU zero-extend; D passes through. With DATA_W=32,
//    W passes through.
//  - rsp_rdata, rsp_err and exc_* hold until the next rsp_valid.
// STRUCTURE
//  - Shared package lsu_pkg: op encodings, state encoding, NB/LANE_W derived constants,
//    and the alignment-check function.
//  - One sub-module, lsu_lane_align: purely combinational store replicate/byte-enable and
//    load extract/extend. Instantiated once; the FSM, counter and registers stay in m_lsu.
// TESTING
//  1 DATA_W=32: lb addr=0x3, bus_rdata=0x80FF_0000, ack in first REQ cycle
//    -> rsp_rdata=0xFFFF_FF80, stall=1 for 2 cycles, rsp_valid in cycle 3.
//  2 sh addr=0x2, wdata=0x0000_BEEF -> bus_be=4'b1100, bus_wdata=0xBEEF_BEEF, bus_addr=0x0.
//  3 lw addr=0x6 -> no bus_req; exc_adel=1 with rsp_valid in cycle 2; sh addr=0x1 -> exc_ades=1.
//  4 lhu addr=0x0, ack withheld -> after TIMEOUT=15 REQ cycles: rsp_err=1, rsp_rdata=0;
//    a late ack is ignored.
//  5 DATA_W=64: lwu addr=0x4, bus_rdata=0xF000_0001_0000_0000 -> rsp_rdata=0x0000_0000_F000_0001;
//    sd addr=0x8 -> bus_be=8'hFF.
//  6 reset asserted in REQ with ack pending -> next cycle bus_req=0 and state IDLE; the
//    following lbu executes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the M-stage load/store unit: op and state encodings,
// lane-geometry helpers and the access legality checks.
package lsu_pkg;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_W    = 3'd1;
  localparam logic [2:0] OP_H    = 3'd2;
  localparam logic [2:0] OP_B    = 3'd3;
  localparam logic [2:0] OP_HU   = 3'd4;
  localparam logic [2:0] OP_BU   = 3'd5;
  localparam logic [2:0] OP_D    = 3'd6;
  localparam logic [2:0] OP_WU   = 3'd7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  function automatic int nb_of(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int lane_w_of(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic logic is_aligned(input logic [2:0] op, input logic [2:0] addr_lo);
    case (op)
      OP_W, OP_WU: is_aligned = (addr_lo[1:0] == 2'b00);
      OP_H, OP_HU: is_aligned = ~addr_lo[0];
      OP_D:        is_aligned = (addr_lo == 3'b000);
      default:     is_aligned = 1'b1;
    endcase
  endfunction

  // Unsigned variants have no store meaning; D/WU need a 64-bit datapath.
  function automatic logic is_illegal(input logic [2:0] op, input logic we, input logic wide);
    is_illegal = (we && (op == OP_HU || op == OP_BU || op == OP_WU)) ||
                 (!wide && (op == OP_D || op == OP_WU));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store-data replication with byte enables, and
// load-data extraction with sign/zero extension.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int LANE_W = $clog2(DATA_W / 8)
) (
  input  logic [2:0]        op,
  input  logic [LANE_W-1:0] lane,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [NB-1:0]     be,
  output logic [DATA_W-1:0] wdata_rep,
  output logic [DATA_W-1:0] rdata_ext
);

  logic [DATA_W-1:0] rep_b;
  logic [DATA_W-1:0] rep_h;
  logic [DATA_W-1:0] rep_w;
  logic [DATA_W-1:0] rd_shift;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_rep
      assign rep_b[gi*8 +: 8] = wdata[7:0];
      assign rep_h[gi*8 +: 8] = wdata[(gi%2)*8 +: 8];
      assign rep_w[gi*8 +: 8] = wdata[(gi%4)*8 +: 8];
    end
  endgenerate

  assign rd_shift = rdata >> {lane, 3'b000};

  always_comb begin
    be        = '1;
    wdata_rep = wdata;
    rdata_ext = rdata;
    case (op)
      OP_B: begin
        be        = NB'(1) << lane;
        wdata_rep = rep_b;
        rdata_ext = DATA_W'($signed(rd_shift[7:0]));
      end
      OP_BU: begin
        be        = NB'(1) << lane;
        wdata_rep = rep_b;
        rdata_ext = DATA_W'(rd_shift[7:0]);
      end
      OP_H: begin
        be        = NB'(3) << lane;
        wdata_rep = rep_h;
        rdata_ext = DATA_W'($signed(rd_shift[15:0]));
      end
      OP_HU: begin
        be        = NB'(3) << lane;
        wdata_rep = rep_h;
        rdata_ext = DATA_W'(rd_shift[15:0]);
      end
      OP_W: begin
        be        = NB'(15) << lane;
        wdata_rep = rep_w;
        rdata_ext = DATA_W'($signed(rd_shift[31:0]));
      end
      OP_WU: begin
        be        = NB'(15) << lane;
        wdata_rep = rep_w;
        rdata_ext = DATA_W'(rd_shift[31:0]);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/m_lsu.sv
// M-stage load/store unit: handshaked data-memory port that stalls the pipeline
// until the access completes, faults or times out.
module m_lsu
  import lsu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [2:0]            req_op,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  stall,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  exc_adel,
  output logic                  exc_ades,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W/8-1:0]   bus_be,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_W-1:0]     bus_rdata,
  input  logic                  bus_err
);

  localparam int NB     = nb_of(DATA_W);
  localparam int LANE_W = lane_w_of(DATA_W);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  logic [1:0]        state_reg, state_next;
  logic [2:0]        op_reg;
  logic              we_reg;
  logic [LANE_W-1:0] lane_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [ADDR_W-1:0] bus_addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rsp_rdata_reg;
  logic              rsp_err_reg, exc_adel_reg, exc_ades_reg;

  logic              start, aligned, illegal, timed_out;
  logic [NB-1:0]     align_be;
  logic [DATA_W-1:0] align_wdata, rdata_ext;

  assign start     = req_valid && (req_op != OP_NONE);
  assign aligned   = is_aligned(req_op, req_addr[2:0]);
  assign illegal   = is_illegal(req_op, req_we, DATA_W == 64);
  assign timed_out = (cnt_reg == CNT_W'(TIMEOUT - 1));

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .op        (op_reg),
    .lane      (lane_reg),
    .wdata     (wdata_reg),
    .rdata     (bus_rdata),
    .be        (align_be),
    .wdata_rep (align_wdata),
    .rdata_ext (rdata_ext)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = (aligned && !illegal) ? ST_REQ : ST_FAULT;
      ST_REQ:  if (bus_ack || timed_out) state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      op_reg        <= OP_NONE;
      we_reg        <= 1'b0;
      lane_reg      <= '0;
      cnt_reg       <= '0;
      bus_addr_reg  <= '0;
      wdata_reg     <= '0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
      exc_adel_reg  <= 1'b0;
      exc_ades_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: if (start) begin
          if (aligned && !illegal) begin
            op_reg       <= req_op;
            we_reg       <= req_we;
            lane_reg     <= req_addr[LANE_W-1:0];
            cnt_reg      <= '0;
            bus_addr_reg <= {req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
            wdata_reg    <= req_wdata;
          end else begin
            // Misalignment takes priority; rsp_err flags only aligned illegal ops.
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= aligned && illegal;
            exc_adel_reg  <= !aligned && !req_we;
            exc_ades_reg  <= !aligned && req_we;
          end
        end
        ST_REQ: begin
          if (bus_ack) begin
            rsp_rdata_reg <= (we_reg || bus_err) ? '0 : rdata_ext;
            rsp_err_reg   <= bus_err;
            exc_adel_reg  <= 1'b0;
            exc_ades_reg  <= 1'b0;
          end else if (timed_out) begin
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b1;
            exc_adel_reg  <= 1'b0;
            exc_ades_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign stall     = !reset && ((state_reg == ST_IDLE && start) || state_reg == ST_REQ);
  assign rsp_valid = (state_reg == ST_DONE) || (state_reg == ST_FAULT);
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;
  assign exc_adel  = exc_adel_reg;
  assign exc_ades  = exc_ades_reg;
  assign bus_req   = (state_reg == ST_REQ);
  assign bus_we    = we_reg;
  assign bus_addr  = bus_addr_reg;
  assign bus_be    = (state_reg != ST_REQ) ? '0 : (we_reg ? align_be : '1);
  assign bus_wdata = align_wdata;

endmodule

// File: tb/tb_m_lsu.sv
// Scoreboard bench for m_lsu: one 32-bit and one 64-bit instance, directed
// vectors with hand-computed responses checked by independent monitors.
module tb_m_lsu;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    logic        adel;
    logic        ades;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // 32-bit instance
  logic        a_req_valid, a_req_we;
  logic [2:0]  a_req_op;
  logic [31:0] a_req_addr, a_req_wdata;
  logic        a_stall, a_rsp_valid, a_rsp_err, a_exc_adel, a_exc_ades;
  logic [31:0] a_rsp_rdata;
  logic        a_bus_req, a_bus_we, a_bus_ack, a_bus_err;
  logic [31:0] a_bus_addr, a_bus_wdata, a_bus_rdata;
  logic [3:0]  a_bus_be;
  logic        a_ack_en, a_ack_force;
  assign a_bus_ack = (a_bus_req & a_ack_en) | a_ack_force;

  // 64-bit instance
  logic        b_req_valid, b_req_we;
  logic [2:0]  b_req_op;
  logic [31:0] b_req_addr;
  logic [63:0] b_req_wdata;
  logic        b_stall, b_rsp_valid, b_rsp_err, b_exc_adel, b_exc_ades;
  logic [63:0] b_rsp_rdata;
  logic        b_bus_req, b_bus_we, b_bus_ack, b_bus_err;
  logic [31:0] b_bus_addr;
  logic [63:0] b_bus_wdata, b_bus_rdata;
  logic [7:0]  b_bus_be;
  assign b_bus_ack = b_bus_req;

  m_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(15)) u_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_we(a_req_we), .req_op(a_req_op),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .stall(a_stall), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
    .rsp_err(a_rsp_err), .exc_adel(a_exc_adel), .exc_ades(a_exc_ades),
    .bus_req(a_bus_req), .bus_we(a_bus_we), .bus_addr(a_bus_addr),
    .bus_be(a_bus_be), .bus_wdata(a_bus_wdata),
    .bus_ack(a_bus_ack), .bus_rdata(a_bus_rdata), .bus_err(a_bus_err)
  );

  m_lsu #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(15)) u_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_we(b_req_we), .req_op(b_req_op),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .stall(b_stall), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .exc_adel(b_exc_adel), .exc_ades(b_exc_ades),
    .bus_req(b_bus_req), .bus_we(b_bus_we), .bus_addr(b_bus_addr),
    .bus_be(b_bus_be), .bus_wdata(b_bus_wdata),
    .bus_ack(b_bus_ack), .bus_rdata(b_bus_rdata), .bus_err(b_bus_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] rd, input logic err, input logic adel, input logic ades);
    exp_t e;
    e.rdata = rd; e.err = err; e.adel = adel; e.ades = ades;
    return e;
  endfunction

  // Monitors: pop one expectation per completion pulse
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!reset && a_rsp_valid) begin
      if (qa.size() == 0) check("a_unexpected_rsp", 1, 0);
      else begin
        e = qa.pop_front();
        check("a_rsp_rdata", {32'h0, a_rsp_rdata}, e.rdata);
        check("a_rsp_err", a_rsp_err, e.err);
        check("a_exc_adel", a_exc_adel, e.adel);
        check("a_exc_ades", a_exc_ades, e.ades);
        $display("a rsp rdata=%h err=%b adel=%b ades=%b", a_rsp_rdata, a_rsp_err, a_exc_adel, a_exc_ades);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (!reset && b_rsp_valid) begin
      if (qb.size() == 0) check("b_unexpected_rsp", 1, 0);
      else begin
        e = qb.pop_front();
        check("b_rsp_rdata", b_rsp_rdata, e.rdata);
        check("b_rsp_err", b_rsp_err, e.err);
        check("b_exc_adel", b_exc_adel, e.adel);
        check("b_exc_ades", b_exc_ades, e.ades);
        $display("b rsp rdata=%h err=%b adel=%b ades=%b", b_rsp_rdata, b_rsp_err, b_exc_adel, b_exc_ades);
      end
    end
  end

  task automatic issue_a(input logic we, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    a_req_valid = 1'b1; a_req_we = we; a_req_op = op; a_req_addr = addr; a_req_wdata = wd;
    @(negedge clk);
    check("a_stall_c1", a_stall, 1);
    check("a_bus_req_c1", a_bus_req, 0);
    @(posedge clk); #1;
    a_req_valid = 1'b0;
  endtask

  task automatic bus_phase_a(input logic we, input logic [31:0] ex_addr, input logic [3:0] ex_be, input logic [31:0] ex_wd);
    @(negedge clk);
    check("a_stall_c2", a_stall, 1);
    check("a_bus_req_c2", a_bus_req, 1);
    check("a_bus_we", a_bus_we, we);
    check("a_bus_addr", a_bus_addr, ex_addr);
    check("a_bus_be", a_bus_be, ex_be);
    if (we) check("a_bus_wdata", a_bus_wdata, ex_wd);
    @(posedge clk); #1;
    @(negedge clk);
    check("a_stall_c3", a_stall, 0);
    check("a_rsp_valid_c3", a_rsp_valid, 1);
    @(posedge clk); #1;
  endtask

  task automatic load_a(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rd,
                        input logic berr, input logic [31:0] ex_rd);
    a_bus_rdata = rd; a_bus_err = berr;
    qa.push_back(mk({32'h0, ex_rd}, berr, 0, 0));
    issue_a(0, op, addr, 32'h0);
    bus_phase_a(0, {addr[31:2], 2'b00}, 4'hF, 32'h0);
    a_bus_err = 1'b0;
  endtask

  task automatic store_a(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] ex_be, input logic [31:0] ex_wd);
    qa.push_back(mk(64'h0, 0, 0, 0));
    issue_a(1, op, addr, wd);
    bus_phase_a(1, {addr[31:2], 2'b00}, ex_be, ex_wd);
  endtask

  task automatic fault_a(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic err, input logic adel, input logic ades);
    qa.push_back(mk(64'h0, err, adel, ades));
    issue_a(we, op, addr, 32'h1234_5678);
    @(negedge clk);
    check("a_fault_rsp_c2", a_rsp_valid, 1);
    check("a_fault_no_bus", a_bus_req, 0);
    check("a_fault_stall", a_stall, 0);
    @(posedge clk); #1;
  endtask

  task automatic access_b(input logic we, input logic [2:0] op, input logic [31:0] addr,
                          input logic [63:0] wd_or_rd, input logic [7:0] ex_be,
                          input logic [63:0] ex_wd, input logic [63:0] ex_rd);
    b_bus_rdata = wd_or_rd;
    qb.push_back(mk(ex_rd, 0, 0, 0));
    b_req_valid = 1'b1; b_req_we = we; b_req_op = op; b_req_addr = addr; b_req_wdata = wd_or_rd;
    @(negedge clk);
    check("b_stall_c1", b_stall, 1);
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    @(negedge clk);
    check("b_bus_req_c2", b_bus_req, 1);
    check("b_bus_addr", b_bus_addr, {addr[31:3], 3'b000});
    check("b_bus_be", b_bus_be, ex_be);
    if (we) check("b_bus_wdata", b_bus_wdata, ex_wd);
    @(posedge clk); #1;
    @(negedge clk);
    check("b_rsp_valid_c3", b_rsp_valid, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    logic seen;
    reset = 1'b1;
    a_req_valid = 0; a_req_we = 0; a_req_op = 0; a_req_addr = 0; a_req_wdata = 0;
    a_bus_rdata = 0; a_bus_err = 0; a_ack_en = 1; a_ack_force = 0;
    b_req_valid = 0; b_req_we = 0; b_req_op = 0; b_req_addr = 0; b_req_wdata = 0;
    b_bus_rdata = 0; b_bus_err = 0;

    @(negedge clk);
    check("a_rst_bus_req", a_bus_req, 0);
    check("a_rst_rsp_valid", a_rsp_valid, 0);
    check("a_rst_stall", a_stall, 0);
    check("a_rst_rsp_rdata", a_rsp_rdata, 0);
    check("a_rst_rsp_err", a_rsp_err, 0);
    check("a_rst_exc", {a_exc_adel, a_exc_ades}, 0);
    check("a_rst_bus_be", a_bus_be, 0);
    check("a_rst_bus_addr", a_bus_addr, 0);
    check("b_rst_bus_req", b_bus_req, 0);
    check("b_rst_rsp_valid", b_rsp_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 32-bit loads
    load_a(OP_B,  32'h3, 32'h80FF_0000, 0, 32'hFFFF_FF80);
    load_a(OP_H,  32'h0, 32'h0000_8001, 0, 32'hFFFF_8001);
    load_a(OP_BU, 32'h1, 32'h0000_9A00, 0, 32'h0000_009A);
    load_a(OP_HU, 32'h2, 32'h8001_0000, 0, 32'h0000_8001);
    load_a(OP_W,  32'h4, 32'h1234_5678, 0, 32'h1234_5678);
    load_a(OP_B,  32'h0, 32'h0000_00FF, 1, 32'h0);
    // 32-bit stores
    store_a(OP_H, 32'h2,  32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF);
    store_a(OP_B, 32'h11, 32'h0000_005A, 4'b0010, 32'h5A5A_5A5A);
    store_a(OP_W, 32'h8,  32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    // Faults: misaligned, illegal, misaligned beats illegal
    fault_a(0, OP_W,  32'h6, 0, 1, 0);
    fault_a(1, OP_H,  32'h1, 0, 0, 1);
    fault_a(0, OP_HU, 32'h3, 0, 1, 0);
    fault_a(1, OP_BU, 32'h0, 1, 0, 0);
    fault_a(0, OP_WU, 32'h0, 1, 0, 0);
    fault_a(0, OP_D,  32'h0, 1, 0, 0);
    fault_a(1, OP_WU, 32'h2, 0, 0, 1);

    // Timeout: ack withheld, then a late ack must be ignored
    a_ack_en = 1'b0;
    qa.push_back(mk(64'h0, 1, 0, 0));
    issue_a(0, OP_HU, 32'h0, 32'h0);
    n = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (a_bus_req) n++;
      if (a_rsp_valid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("a_timeout_req_cycles", n, 15);
    check("a_timeout_rsp_seen", seen, 1);
    a_ack_force = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("a_late_ack_no_rsp", a_rsp_valid, 0);
    check("a_late_ack_no_req", a_bus_req, 0);
    @(posedge clk); #1;
    a_ack_force = 1'b0;
    @(negedge clk);
    check("a_err_hold", a_rsp_err, 1);
    check("a_rdata_hold", a_rsp_rdata, 0);
    @(posedge clk); #1;

    // Reset mid-access with an ack pending
    issue_a(0, OP_B, 32'h0, 32'h0);
    @(negedge clk);
    check("a_rst_mid_req", a_bus_req, 1);
    @(posedge clk); #1;
    reset = 1'b1; a_ack_en = 1'b1;
    @(negedge clk);
    check("a_rst_stall_forced", a_stall, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("a_post_rst_bus_req", a_bus_req, 0);
    check("a_post_rst_rsp_valid", a_rsp_valid, 0);
    check("a_post_rst_stall", a_stall, 0);
    @(posedge clk); #1;
    load_a(OP_BU, 32'h2, 32'h00AB_0000, 0, 32'h0000_00AB);

    // 64-bit instance
    access_b(0, OP_WU, 32'h4, 64'hF000_0001_0000_0000, 8'hFF, 64'h0, 64'h0000_0000_F000_0001);
    access_b(0, OP_W,  32'h4, 64'hF000_0001_0000_0000, 8'hFF, 64'h0, 64'hFFFF_FFFF_F000_0001);
    access_b(0, OP_D,  32'h8, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 64'h0123_4567_89AB_CDEF);
    access_b(0, OP_H,  32'h6, 64'h8765_0000_0000_0000, 8'hFF, 64'h0, 64'hFFFF_FFFF_FFFF_8765);
    access_b(1, OP_D,  32'h8, 64'h1122_3344_5566_7788, 8'hFF, 64'h1122_3344_5566_7788, 64'h0);
    access_b(1, OP_W,  32'h4, 64'h0000_0000_CAFE_BABE, 8'hF0, 64'hCAFE_BABE_CAFE_BABE, 64'h0);
    qb.push_back(mk(64'h0, 0, 1, 0));
    b_req_valid = 1'b1; b_req_we = 0; b_req_op = OP_D; b_req_addr = 32'h4;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    @(negedge clk);
    check("b_fault_no_bus", b_bus_req, 0);
    @(posedge clk); #1;

    repeat (2) @(posedge clk);
    #1;
    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
